// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register. The main (head) entry drives the outputs
// and the skid entry absorbs one extra upstream entry. Because of the skid
// entry, in_ready can come straight from a flop and does not depend on
// out_ready in the same cycle. Bubbles always show an all-zero control word,
// so downstream logic can treat them as a NOP.
module pipe_stage_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CTRL_W    = 16,
  parameter bit          ZERO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;

  logic                accept;
  logic                consume;

  // Flush kills both transfers in the cycle it is asserted.
  assign accept  = in_valid && in_ready_q && !flush;
  assign consume = (state_q != StEmpty) && out_ready && !flush;

  // State register and registered ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state: occupancy moves by accept minus consume, flush forces empty.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) state_d = StOne;
        end
        StOne: begin
          if (accept && !consume) begin
            state_d = StFull;
          end else if (consume && !accept) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (consume) state_d = StOne;
        end
        default: state_d = StEmpty;
      endcase
    end
    // Ready for the next cycle is known as soon as the next occupancy is.
    in_ready_d = (state_d != StFull);
  end

  // Outputs decoded from the state and the head entry.
  always_comb begin
    out_valid = (state_q != StEmpty);
    occupancy = state_q;
    in_ready  = in_ready_q;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    out_data  = main_data_q;
  end

  // Entry steering: where an accepted entry lands and how skid refills main.
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (ZERO_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        StOne: begin
          if (accept && consume) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (consume) begin
            // Leave a NOP behind so a stale control word never lingers.
            main_ctrl_d = '0;
          end
        end
        StFull: begin
          if (consume) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised bench for pipe_stage_reg. Inputs change and outputs
// are sampled on the falling clock edge; the DUT updates on the rising edge.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_ctrl = '0;
  logic [31:0] in_data = '0;

  // Instance with data zeroing on flush (default).
  logic        in_ready, out_valid;
  logic [15:0] out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  // Instance that holds data across a flush.
  logic        in_ready_h, out_valid_h;
  logic [15:0] out_ctrl_h;
  logic [31:0] out_data_h;
  logic [1:0]  occupancy_h;

  int tests_run = 0;
  int failed = 0;

  // Packed view: {valid, occupancy, in_ready, ctrl, data}.
  logic [51:0] obs, obs_h;
  assign obs   = {out_valid, occupancy, in_ready, out_ctrl, out_data};
  assign obs_h = {out_valid_h, occupancy_h, in_ready_h, out_ctrl_h, out_data_h};

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  pipe_stage_reg #(.ZERO_DATA(1'b0)) dut_h (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready_h),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid_h),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl_h),
    .out_data  (out_data_h),
    .occupancy (occupancy_h)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (obs !== {1'b0, 2'd0, 1'b1, 16'h0, 32'h0}) begin
      failed++; $display("FAIL reset_z: got %h want %h", obs, {1'b0, 2'd0, 1'b1, 16'h0, 32'h0});
    end
    tests_run++;
    if (obs_h !== {1'b0, 2'd0, 1'b1, 16'h0, 32'h0}) begin
      failed++; $display("FAIL reset_h: got %h want %h", obs_h, {1'b0, 2'd0, 1'b1, 16'h0, 32'h0});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h11; in_ctrl = 16'h0101;
    @(negedge clk);
    tests_run++;
    if (obs !== {1'b1, 2'd1, 1'b1, 16'h0101, 32'h11}) begin
      failed++; $display("FAIL stream_11: got %h want %h", obs, {1'b1, 2'd1, 1'b1, 16'h0101, 32'h11});
    end
    in_data = 32'h22; in_ctrl = 16'h0202;
    @(negedge clk);
    tests_run++;
    if (obs !== {1'b1, 2'd1, 1'b1, 16'h0202, 32'h22}) begin
      failed++; $display("FAIL stream_22: got %h want %h", obs, {1'b1, 2'd1, 1'b1, 16'h0202, 32'h22});
    end
    in_data = 32'h33; in_ctrl = 16'h0303;
    @(negedge clk);
    tests_run++;
    if (obs !== {1'b1, 2'd1, 1'b1, 16'h0303, 32'h33}) begin
      failed++; $display("FAIL stream_33: got %h want %h", obs, {1'b1, 2'd1, 1'b1, 16'h0303, 32'h33});
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs[51:32] !== {1'b0, 2'd0, 1'b1, 16'h0}) begin
      failed++; $display("FAIL stream_drain: got %h want %h", obs[51:32], {1'b0, 2'd0, 1'b1, 16'h0});
    end
  endtask

  task automatic test_skid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA0; in_ctrl = 16'h00A0;
    @(negedge clk);
    tests_run++;
    if (obs !== {1'b1, 2'd1, 1'b1, 16'h00A0, 32'hA0}) begin
      failed++; $display("FAIL skid_one: got %h want %h", obs, {1'b1, 2'd1, 1'b1, 16'h00A0, 32'hA0});
    end
    in_data = 32'hB0; in_ctrl = 16'h00B0;
    @(negedge clk);
    tests_run++;
    if (obs !== {1'b1, 2'd2, 1'b0, 16'h00A0, 32'hA0}) begin
      failed++; $display("FAIL skid_full: got %h want %h", obs, {1'b1, 2'd2, 1'b0, 16'h00A0, 32'hA0});
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs !== {1'b1, 2'd2, 1'b0, 16'h00A0, 32'hA0}) begin
      failed++; $display("FAIL skid_stable: got %h want %h", obs, {1'b1, 2'd2, 1'b0, 16'h00A0, 32'hA0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs !== {1'b1, 2'd1, 1'b1, 16'h00B0, 32'hB0}) begin
      failed++; $display("FAIL skid_move: got %h want %h", obs, {1'b1, 2'd1, 1'b1, 16'h00B0, 32'hB0});
    end
    @(negedge clk);
    tests_run++;
    if (obs[51:32] !== {1'b0, 2'd0, 1'b1, 16'h0}) begin
      failed++; $display("FAIL skid_empty: got %h want %h", obs[51:32], {1'b0, 2'd0, 1'b1, 16'h0});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_full();
    do_reset();
    in_valid = 1'b1; in_data = 32'hD0; in_ctrl = 16'h0D0D;
    @(negedge clk);
    in_data = 32'hE0; in_ctrl = 16'h0E0E;
    @(negedge clk);
    tests_run++;
    if (obs !== {1'b1, 2'd2, 1'b0, 16'h0D0D, 32'hD0}) begin
      failed++; $display("FAIL flush_prefill: got %h want %h", obs, {1'b1, 2'd2, 1'b0, 16'h0D0D, 32'hD0});
    end
    flush = 1'b1; out_ready = 1'b1; in_data = 32'hC0; in_ctrl = 16'h0C0C;
    @(negedge clk);
    tests_run++;
    if (obs !== {1'b0, 2'd0, 1'b1, 16'h0, 32'h0}) begin
      failed++; $display("FAIL flush_kill: got %h want %h", obs, {1'b0, 2'd0, 1'b1, 16'h0, 32'h0});
    end
    tests_run++;
    if (obs_h[51:32] !== {1'b0, 2'd0, 1'b1, 16'h0}) begin
      failed++; $display("FAIL flush_kill_h: got %h want %h", obs_h[51:32], {1'b0, 2'd0, 1'b1, 16'h0});
    end
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs[51:32] !== {1'b0, 2'd0, 1'b1, 16'h0}) begin
        failed++; $display("FAIL flush_no_c0 cycle %0d: got %h want %h", i, obs[51:32],
                           {1'b0, 2'd0, 1'b1, 16'h0});
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_zero_data();
    do_reset();
    in_valid = 1'b1; in_data = 32'h5A5A; in_ctrl = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (obs_h !== {1'b1, 2'd1, 1'b1, 16'h1234, 32'h5A5A}) begin
      failed++; $display("FAIL zd_hold_pre: got %h want %h", obs_h, {1'b1, 2'd1, 1'b1, 16'h1234, 32'h5A5A});
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (obs_h !== {1'b0, 2'd0, 1'b1, 16'h0, 32'h5A5A}) begin
      failed++; $display("FAIL zd_hold_post: got %h want %h", obs_h, {1'b0, 2'd0, 1'b1, 16'h0, 32'h5A5A});
    end
    tests_run++;
    if (obs !== {1'b0, 2'd0, 1'b1, 16'h0, 32'h0}) begin
      failed++; $display("FAIL zd_zero_post: got %h want %h", obs, {1'b0, 2'd0, 1'b1, 16'h0, 32'h0});
    end
    @(negedge clk);
    tests_run++;
    if (obs_h !== {1'b0, 2'd0, 1'b1, 16'h0, 32'h5A5A}) begin
      failed++; $display("FAIL zd_hold_later: got %h want %h", obs_h, {1'b0, 2'd0, 1'b1, 16'h0, 32'h5A5A});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_data = 32'hF1; in_ctrl = 16'h00F1;
    @(negedge clk);
    in_data = 32'hF2; in_ctrl = 16'h00F2;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (obs !== {1'b1, 2'd2, 1'b0, 16'h00F1, 32'hF1}) begin
      failed++; $display("FAIL arst_prefill: got %h want %h", obs, {1'b1, 2'd2, 1'b0, 16'h00F1, 32'hF1});
    end
    // Assert reset mid-phase, well before the next rising edge.
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (obs !== {1'b0, 2'd0, 1'b1, 16'h0, 32'h0}) begin
      failed++; $display("FAIL arst_immediate: got %h want %h", obs, {1'b0, 2'd0, 1'b1, 16'h0, 32'h0});
    end
    tests_run++;
    if (obs_h !== {1'b0, 2'd0, 1'b1, 16'h0, 32'h0}) begin
      failed++; $display("FAIL arst_immediate_h: got %h want %h", obs_h, {1'b0, 2'd0, 1'b1, 16'h0, 32'h0});
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'h77; in_ctrl = 16'h0077;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (obs !== {1'b1, 2'd1, 1'b1, 16'h0077, 32'h77}) begin
      failed++; $display("FAIL arst_push77: got %h want %h", obs, {1'b1, 2'd1, 1'b1, 16'h0077, 32'h77});
    end
    // The skid entry must be empty too: the next head after 0x77 is a bubble.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (obs[51:32] !== {1'b0, 2'd0, 1'b1, 16'h0}) begin
      failed++; $display("FAIL arst_no_stale: got %h want %h", obs[51:32], {1'b0, 2'd0, 1'b1, 16'h0});
    end
  endtask

  task automatic test_random();
    logic [47:0] sb[$];
    logic        acc, con;
    logic [51:0] want;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 3);
      in_data   = $urandom;
      in_ctrl   = 16'($urandom_range(0, 65535));
      acc = in_valid && (sb.size() != 2) && !flush;
      con = (sb.size() != 0) && out_ready && !flush;
      @(negedge clk);
      if (flush) begin
        sb.delete();
      end else begin
        if (con) void'(sb.pop_front());
        if (acc) sb.push_back({in_ctrl, in_data});
      end
      tests_run++;
      if (sb.size() == 0) begin
        if (obs[51:32] !== {1'b0, 2'd0, 1'b1, 16'h0}) begin
          failed++; $display("FAIL random cycle %0d: got %h want %h", cyc, obs[51:32],
                             {1'b0, 2'd0, 1'b1, 16'h0});
        end
      end else begin
        want = {1'b1, 2'(sb.size()), (sb.size() != 2), sb[0]};
        if (obs !== want) begin
          failed++; $display("FAIL random cycle %0d: got %h want %h", cyc, obs, want);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush_full();
    test_zero_data();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
